// File: rtl/uart_pkg.sv
// Shared types and clocking constants for the UART transmit path.
// The default bit period is derived from the system clock and MIDI baud rate.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } uart_tx_state_t;

  localparam int unsigned UART_CLK_HZ      = 100_000_000;
  localparam int unsigned UART_BAUD        = 31250;
  localparam int unsigned UART_CLK_PER_BIT = UART_CLK_HZ / UART_BAUD;

endpackage

// File: rtl/byte_fifo.sv
// Small first-word-fall-through FIFO: dout always shows the oldest entry while !empty.
// Writes when full and reads when empty are ignored.
module byte_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_100mhz,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push, pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(DEPTH));
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;
  assign dout  = mem[rd_ptr_q];

  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; contents are only visible through count_q.
  always_ff @(posedge clk_100mhz) begin
    if (push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_encoder.sv
// 8N1 UART transmitter fed by a byte FIFO; frames follow each other with no idle gap.
// UART_out is driven straight from a flop so the pin never glitches.
module uart_encoder
  import uart_pkg::*;
#(
  parameter int unsigned CLK_CYCLES_PER_UART_BIT = UART_CLK_PER_BIT,
  parameter int unsigned FIFO_DEPTH              = 4
) (
  input  logic       clk_100mhz,
  input  logic       reset,
  input  logic [7:0] val_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       UART_out,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(CLK_CYCLES_PER_UART_BIT);
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_CYCLES_PER_UART_BIT - 1);

  uart_tx_state_t  state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            uart_q, uart_d;

  logic       fifo_rd, fifo_empty, fifo_full;
  logic [7:0] fifo_dout;
  logic       bit_done;

  byte_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_100mhz (clk_100mhz),
    .reset      (reset),
    .wr_en      (valid_in),
    .din        (val_in),
    .rd_en      (fifo_rd),
    .dout       (fifo_dout),
    .empty      (fifo_empty),
    .full       (fifo_full)
  );

  assign bit_done  = (cnt_q == CntMax);
  assign ready_out = !fifo_full;
  assign busy      = (state_q != IDLE) || !fifo_empty;
  assign UART_out  = uart_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    uart_d    = uart_q;
    fifo_rd   = 1'b0;
    unique case (state_q)
      IDLE: begin
        uart_d    = 1'b1;
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!fifo_empty) begin
          fifo_rd = 1'b1;
          shift_d = fifo_dout;
          state_d = START_BIT;
          uart_d  = 1'b0;
        end
      end
      START_BIT: begin
        if (bit_done) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = DATA_BITS;
          uart_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DATA_BITS: begin
        if (bit_done) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP_BIT;
            uart_d  = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            uart_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      STOP_BIT: begin
        if (bit_done) begin
          cnt_d = '0;
          // Chain straight into the next start bit when more data is waiting.
          if (!fifo_empty) begin
            fifo_rd = 1'b1;
            shift_d = fifo_dout;
            state_d = START_BIT;
            uart_d  = 1'b0;
          end else begin
            state_d = IDLE;
            uart_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        uart_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      uart_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      uart_q    <= uart_d;
    end
  end

endmodule

// File: tb/tb_uart_encoder.sv
// Randomised bench for uart_encoder against a frame-timeline reference model.
// A second instance with a 4-cycle bit period covers the short-bit case.
module tb_uart_encoder;

  localparam int N     = 5;
  localparam int DEPTH = 4;
  localparam int N4    = 4;

  logic       clk_100mhz = 1'b0;
  logic       reset      = 1'b1;
  logic [7:0] val_in     = '0;
  logic       valid_in   = 1'b0;
  logic       ready_out, uart_line, busy;
  logic [7:0] val4       = '0;
  logic       valid4     = 1'b0;
  logic       ready4, line4, busy4;

  always #5 clk_100mhz = ~clk_100mhz;

  uart_encoder #(
    .CLK_CYCLES_PER_UART_BIT (N),
    .FIFO_DEPTH              (DEPTH)
  ) dut (
    .clk_100mhz (clk_100mhz),
    .reset      (reset),
    .val_in     (val_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .UART_out   (uart_line),
    .busy       (busy)
  );

  uart_encoder #(
    .CLK_CYCLES_PER_UART_BIT (N4),
    .FIFO_DEPTH              (DEPTH)
  ) dut4 (
    .clk_100mhz (clk_100mhz),
    .reset      (reset),
    .val_in     (val4),
    .valid_in   (valid4),
    .ready_out  (ready4),
    .UART_out   (line4),
    .busy       (busy4)
  );

  int         assertions = 0;
  int         failures   = 0;
  int         cyc        = 0;
  int         q_start[$];
  logic [7:0] q_byte[$];
  logic       exp_line, exp_busy, exp_ready, last_acc;

  // Bytes not yet popped before edge t are those whose start edge is t or later.
  function automatic int model_count(int t);
    int c = 0;
    foreach (q_start[i]) if (q_start[i] >= t) c++;
    return c;
  endfunction

  // Drive one cycle and advance the model: each accepted byte owns the window
  // [start, start+10N) on the line, starting one edge after acceptance or when
  // the previous frame ends, whichever is later.
  task automatic step(input logic v, input logic [7:0] d);
    int s, k;
    valid_in = v;
    val_in   = d;
    last_acc = v && (model_count(cyc + 1) < DEPTH);
    @(posedge clk_100mhz);
    cyc++;
    while (q_start.size() > 0 && q_start[0] + 10 * N <= cyc) begin
      q_start.delete(0);
      q_byte.delete(0);
    end
    if (last_acc) begin
      s = cyc + 1;
      if (q_start.size() > 0 && q_start[$] + 10 * N > s) s = q_start[$] + 10 * N;
      q_start.push_back(s);
      q_byte.push_back(d);
    end
    exp_busy  = (q_start.size() > 0);
    exp_ready = (model_count(cyc + 1) < DEPTH);
    exp_line  = 1'b1;
    if (q_start.size() > 0 && q_start[0] <= cyc) begin
      k = (cyc - q_start[0]) / N;
      if (k == 0) exp_line = 1'b0;
      else if (k <= 8) exp_line = q_byte[0][k-1];
    end
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    valid_in = 1'b0;
    repeat (2) @(posedge clk_100mhz);
    #1;
    assertions += 6;
    if (uart_line !== 1'b1) begin failures++; $display("FAIL reset_line got=%b exp=1", uart_line); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (ready_out !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready_out); end
    if (line4 !== 1'b1) begin failures++; $display("FAIL reset_line4 got=%b exp=1", line4); end
    if (busy4 !== 1'b0) begin failures++; $display("FAIL reset_busy4 got=%b exp=0", busy4); end
    if (ready4 !== 1'b1) begin failures++; $display("FAIL reset_ready4 got=%b exp=1", ready4); end
    #2 reset = 1'b0;
    q_start.delete();
    q_byte.delete();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00);
      assertions += 3;
      if (uart_line !== exp_line) begin failures++; $display("FAIL idle_line cyc=%0d got=%b exp=%b", cyc, uart_line, exp_line); end
      if (busy !== exp_busy) begin failures++; $display("FAIL idle_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); end
      if (ready_out !== exp_ready) begin failures++; $display("FAIL idle_ready cyc=%0d got=%b exp=%b", cyc, ready_out, exp_ready); end
    end
  endtask

  task automatic test_single();
    int e0, fall, bfall;
    fall  = -1;
    bfall = -1;
    step(1'b1, 8'h55);
    e0 = cyc;
    for (int i = 0; i < 10 * N + 4; i++) begin
      if (i > 0) step(1'b0, 8'h00);
      assertions += 3;
      if (uart_line !== exp_line) begin failures++; $display("FAIL single_line cyc=%0d got=%b exp=%b", cyc, uart_line, exp_line); end
      if (busy !== exp_busy) begin failures++; $display("FAIL single_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); end
      if (ready_out !== exp_ready) begin failures++; $display("FAIL single_ready cyc=%0d got=%b exp=%b", cyc, ready_out, exp_ready); end
      if (fall < 0 && uart_line === 1'b0) fall = cyc;
      if (fall >= 0 && bfall < 0 && busy === 1'b0) bfall = cyc;
    end
    assertions += 2;
    if (fall != e0 + 1) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", fall - e0, 1); end
    if (bfall - fall != 10 * N) begin failures++; $display("FAIL single_frame_len got=%0d exp=%0d", bfall - fall, 10 * N); end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 8'h00);
    for (int i = 0; i < 20 * N + 4; i++) begin
      if (i == 0) step(1'b1, 8'hFF);
      else step(1'b0, 8'h00);
      assertions += 3;
      if (uart_line !== exp_line) begin failures++; $display("FAIL b2b_line cyc=%0d got=%b exp=%b", cyc, uart_line, exp_line); end
      if (busy !== exp_busy) begin failures++; $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); end
      if (ready_out !== exp_ready) begin failures++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", cyc, ready_out, exp_ready); end
    end
  endtask

  task automatic test_fifo_full();
    int idx = 1;
    for (int i = 0; i < 80 * N && !(idx > 6 && q_start.size() == 0); i++) begin
      step(idx <= 6, 8'(idx));
      if (last_acc) idx++;
      assertions += 3;
      if (uart_line !== exp_line) begin failures++; $display("FAIL full_line cyc=%0d got=%b exp=%b", cyc, uart_line, exp_line); end
      if (busy !== exp_busy) begin failures++; $display("FAIL full_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); end
      if (ready_out !== exp_ready) begin failures++; $display("FAIL full_ready cyc=%0d got=%b exp=%b", cyc, ready_out, exp_ready); end
    end
    assertions++;
    if (idx != 7) begin failures++; $display("FAIL full_accepted got=%0d exp=6", idx - 1); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] bytes [3];
    bytes[0] = 8'hA3;
    bytes[1] = 8'h11;
    bytes[2] = 8'h22;
    for (int i = 0; i < 3 + 3 * N + 2; i++) begin
      step(i < 3, (i < 3) ? bytes[i] : 8'h00);
      assertions += 3;
      if (uart_line !== exp_line) begin failures++; $display("FAIL abort_line cyc=%0d got=%b exp=%b", cyc, uart_line, exp_line); end
      if (busy !== exp_busy) begin failures++; $display("FAIL abort_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); end
      if (ready_out !== exp_ready) begin failures++; $display("FAIL abort_ready cyc=%0d got=%b exp=%b", cyc, ready_out, exp_ready); end
    end
    valid_in = 1'b0;
    #1 reset = 1'b1;
    #1;
    assertions += 3;
    if (uart_line !== 1'b1) begin failures++; $display("FAIL abort_rst_line got=%b exp=1", uart_line); end
    if (busy !== 1'b0) begin failures++; $display("FAIL abort_rst_busy got=%b exp=0", busy); end
    if (ready_out !== 1'b1) begin failures++; $display("FAIL abort_rst_ready got=%b exp=1", ready_out); end
    q_start.delete();
    q_byte.delete();
    #2 reset = 1'b0;
    for (int i = 0; i < 12 * N; i++) begin
      step(1'b0, 8'h00);
      assertions += 3;
      if (uart_line !== exp_line) begin failures++; $display("FAIL post_rst_line cyc=%0d got=%b exp=%b", cyc, uart_line, exp_line); end
      if (busy !== exp_busy) begin failures++; $display("FAIL post_rst_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); end
      if (ready_out !== exp_ready) begin failures++; $display("FAIL post_rst_ready cyc=%0d got=%b exp=%b", cyc, ready_out, exp_ready); end
    end
  endtask

  task automatic test_stream();
    int idx = 0;
    for (int i = 0; i < 20000 && !(idx > 255 && q_start.size() == 0); i++) begin
      step((idx <= 255) && ($urandom_range(0, 7) != 0), idx[7:0]);
      if (last_acc) idx++;
      assertions += 3;
      if (uart_line !== exp_line) begin failures++; $display("FAIL stream_line cyc=%0d got=%b exp=%b", cyc, uart_line, exp_line); end
      if (busy !== exp_busy) begin failures++; $display("FAIL stream_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); end
      if (ready_out !== exp_ready) begin failures++; $display("FAIL stream_ready cyc=%0d got=%b exp=%b", cyc, ready_out, exp_ready); end
    end
    assertions++;
    if (idx != 256 || q_start.size() != 0) begin
      failures++;
      $display("FAIL stream_done got=%0d bytes pending=%0d exp=256 pending=0", idx, q_start.size());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      step((i < 450) && ($urandom_range(0, 3) == 0), 8'($urandom));
      assertions += 3;
      if (uart_line !== exp_line) begin failures++; $display("FAIL rand_line cyc=%0d got=%b exp=%b", cyc, uart_line, exp_line); end
      if (busy !== exp_busy) begin failures++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); end
      if (ready_out !== exp_ready) begin failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, ready_out, exp_ready); end
    end
  endtask

  task automatic test_short_bit();
    logic [7:0] b;
    logic       e_line, e_busy;
    int         k;
    b      = 8'h80;
    val4   = b;
    valid4 = 1'b1;
    @(posedge clk_100mhz);
    #1 valid4 = 1'b0;
    assertions += 2;
    if (busy4 !== 1'b1) begin failures++; $display("FAIL short_accept_busy got=%b exp=1", busy4); end
    if (line4 !== 1'b1) begin failures++; $display("FAIL short_accept_line got=%b exp=1", line4); end
    for (int j = 0; j < 45; j++) begin
      @(posedge clk_100mhz);
      #1;
      e_line = 1'b1;
      if (j < 40) begin
        k = j / N4;
        if (k == 0) e_line = 1'b0;
        else if (k <= 8) e_line = b[k-1];
      end
      e_busy = (j < 40);
      assertions += 2;
      if (line4 !== e_line) begin failures++; $display("FAIL short_line j=%0d got=%b exp=%b", j, line4, e_line); end
      if (busy4 !== e_busy) begin failures++; $display("FAIL short_busy j=%0d got=%b exp=%b", j, busy4, e_busy); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_reset_mid_frame();
    test_stream();
    test_random();
    test_short_bit();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
